// File: rtl/gpr_writeback_if.sv
// Handshake and write-port bundle for gpr_writeback.
// Optional bypass lookup signals appear when GPR_WB_BYPASS_EN is defined.
interface gpr_writeback_if #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              wb_hold;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  fifo_count;
`ifdef GPR_WB_BYPASS_EN
  logic [ADDR_W-1:0] byp_addr_1;
  logic [ADDR_W-1:0] byp_addr_2;
  logic              byp_hit_1;
  logic              byp_hit_2;
  logic [DATA_W-1:0] byp_data_1;
  logic [DATA_W-1:0] byp_data_2;

  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, wb_hold,
    input  byp_addr_1, byp_addr_2,
    output alu_ready, mem_ready, wb_en, wb_dest, wb_data, fifo_count,
    output byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
  );
  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, wb_hold,
    output byp_addr_1, byp_addr_2,
    input  alu_ready, mem_ready, wb_en, wb_dest, wb_data, fifo_count,
    input  byp_hit_1, byp_hit_2, byp_data_1, byp_data_2
  );
`else
  modport slave (
    input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, wb_hold,
    output alu_ready, mem_ready, wb_en, wb_dest, wb_data, fifo_count
  );
  modport master (
    output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data, wb_hold,
    input  alu_ready, mem_ready, wb_en, wb_dest, wb_data, fifo_count
  );
`endif
endinterface

// File: rtl/gpr_writeback.sv
// Write-back sequencer for the 8x16 GPR file: arbitrates ALU and load results
// (load unit has priority) into an in-order FIFO and issues one registered
// write per cycle. Optional combinational forwarding lookup: GPR_WB_BYPASS_EN.
module gpr_writeback #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  gpr_writeback_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] dest_q [FIFO_DEPTH];
  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              wb_en_q;
  logic [ADDR_W-1:0] wb_dest_q;
  logic [DATA_W-1:0] wb_data_q;

  logic              full, push, pop, mem_ready, alu_ready;
  logic [ADDR_W-1:0] push_dest;
  logic [DATA_W-1:0] push_data;

  // Readies look only at the current count, so a same-cycle pop never frees a slot.
  always_comb begin
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    mem_ready = !full;
    alu_ready = !full && !bus.mem_valid;
    push      = (bus.mem_valid && mem_ready) || (bus.alu_valid && alu_ready);
    push_dest = bus.mem_valid ? bus.mem_dest : bus.alu_dest;
    push_data = bus.mem_valid ? bus.mem_data : bus.alu_data;
    pop       = (count_q != '0) && !bus.wb_hold;
  end

  assign bus.mem_ready  = mem_ready;
  assign bus.alu_ready  = alu_ready;
  assign bus.wb_en      = wb_en_q;
  assign bus.wb_dest    = wb_dest_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.fifo_count = count_q;

  // Entry storage; contents are meaningless outside the valid window so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr_q] <= push_dest;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers, occupancy and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_dest_q <= '0;
      wb_data_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      wb_en_q <= pop;
      if (pop) begin
        wb_dest_q <= dest_q[rd_ptr_q];
        wb_data_q <= data_q[rd_ptr_q];
      end
    end
  end

`ifdef GPR_WB_BYPASS_EN
  // Oldest first so that younger matches overwrite; the wb register is oldest.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] addr);
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  idx;
    hit  = 1'b0;
    data = '0;
    if (wb_en_q && (wb_dest_q == addr)) begin
      hit  = 1'b1;
      data = wb_data_q;
    end
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((i < 32'(count_q)) && (dest_q[idx] == addr)) begin
        hit  = 1'b1;
        data = data_q[idx];
      end
    end
    return {hit, data};
  endfunction

  logic [DATA_W:0] byp_1, byp_2;

  // Forwarding search for the two decode read ports.
  always_comb begin
    byp_1 = lookup(bus.byp_addr_1);
    byp_2 = lookup(bus.byp_addr_2);
  end

  assign bus.byp_hit_1  = byp_1[DATA_W];
  assign bus.byp_data_1 = byp_1[DATA_W-1:0];
  assign bus.byp_hit_2  = byp_2[DATA_W];
  assign bus.byp_data_2 = byp_2[DATA_W-1:0];
`endif
endmodule

// File: tb/tb_gpr_writeback.sv
// Directed bench for gpr_writeback; includes the bypass scenario when
// GPR_WB_BYPASS_EN is defined.
module tb_gpr_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [15:0] wlog [$];
  logic [15:0] rf [8];

  gpr_writeback_if #(.DATA_W(16), .ADDR_W(3), .FIFO_DEPTH(4)) bus ();

  gpr_writeback #(.DATA_W(16), .ADDR_W(3), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in register file plus a log of every issued write.
  always @(posedge clk) begin
    if (bus.wb_en === 1'b1) begin
      rf[bus.wb_dest] <= bus.wb_data;
      wlog.push_back(bus.wb_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (bus.wb_en !== 1'b0 || bus.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got wb_en=%b cnt=%0d want 0/0", bus.wb_en, bus.fifo_count);
    end
    n_cmp++;
    if (bus.wb_dest !== 3'd0 || bus.wb_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_wb got dest=%0d data=%h want 0/0000", bus.wb_dest, bus.wb_data);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready got alu=%b mem=%b want 1/1", bus.alu_ready, bus.mem_ready);
    end
  endtask

  // Async reset in mid-cycle discards buffered entries.
  task automatic test_reset_flush();
    int base;
    bus.wb_hold   = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 3'd1;
    for (int i = 1; i <= 3; i++) begin
      bus.alu_data = 16'h0E00 + 16'(i);
      tick();
    end
    bus.alu_valid = 1'b0;
    n_cmp++;
    if (bus.fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_fill got cnt=%0d want 3", bus.fifo_count);
    end
    bus.wb_hold = 1'b0;
    tick();
    n_cmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_data !== 16'h0E01 || bus.fifo_count !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_pop got en=%b data=%h cnt=%0d want 1/0e01/2",
               bus.wb_en, bus.wb_data, bus.fifo_count);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.wb_en !== 1'b0 || bus.fifo_count !== 3'd0 || bus.wb_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL flush_async got en=%b cnt=%0d data=%h want 0/0/0000",
               bus.wb_en, bus.fifo_count, bus.wb_data);
    end
    #1 rst = 1'b0;
    base = wlog.size();
    #1;
    n_cmp++;
    if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready got alu=%b mem=%b want 1/1", bus.alu_ready, bus.mem_ready);
    end
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (wlog.size() !== base || bus.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_stale got writes=%0d cnt=%0d want 0/0",
               wlog.size() - base, bus.fifo_count);
    end
  endtask

  task automatic test_single_write();
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 3'd3;
    bus.alu_data  = 16'h00A5;
    #1;
    n_cmp++;
    if (bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ready got %b want 1", bus.alu_ready);
    end
    tick();  // edge k
    bus.alu_valid = 1'b0;
    n_cmp++;
    if (bus.wb_en !== 1'b0 || bus.fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL single_k got en=%b cnt=%0d want 0/1", bus.wb_en, bus.fifo_count);
    end
    tick();  // edge k+1
    n_cmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_dest !== 3'd3 || bus.wb_data !== 16'h00A5) begin
      n_fail++;
      $display("FAIL single_k1 got en=%b dest=%0d data=%h want 1/3/00a5",
               bus.wb_en, bus.wb_dest, bus.wb_data);
    end
    tick();  // edge k+2
    n_cmp++;
    if (bus.wb_en !== 1'b0 || rf[3] !== 16'h00A5) begin
      n_fail++;
      $display("FAIL single_k2 got en=%b r3=%h want 0/00a5", bus.wb_en, rf[3]);
    end
  endtask

  task automatic test_priority();
    int base;
    base = wlog.size();
    bus.mem_valid = 1'b1;
    bus.mem_dest  = 3'd2;
    bus.mem_data  = 16'h1111;
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 3'd2;
    bus.alu_data  = 16'h2222;
    #1;
    n_cmp++;
    if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_ready got mem=%b alu=%b want 1/0", bus.mem_ready, bus.alu_ready);
    end
    tick();
    bus.mem_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_alu_next got %b want 1", bus.alu_ready);
    end
    tick();
    bus.alu_valid = 1'b0;
    n_cmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_data !== 16'h1111) begin
      n_fail++;
      $display("FAIL prio_first got en=%b data=%h want 1/1111", bus.wb_en, bus.wb_data);
    end
    tick();
    n_cmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_data !== 16'h2222) begin
      n_fail++;
      $display("FAIL prio_second got en=%b data=%h want 1/2222", bus.wb_en, bus.wb_data);
    end
    tick();
    n_cmp++;
    if (wlog.size() !== base + 2 || rf[2] !== 16'h2222) begin
      n_fail++;
      $display("FAIL prio_final got writes=%0d r2=%h want 2/2222", wlog.size() - base, rf[2]);
    end
  endtask

  task automatic test_hold();
    bus.wb_hold   = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_dest  = 3'd4;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_data = 16'(i);
      tick();
      n_cmp++;
      if (bus.wb_en !== 1'b0 || bus.fifo_count !== 3'(i)) begin
        n_fail++;
        $display("FAIL hold_fill%0d got en=%b cnt=%0d want 0/%0d", i, bus.wb_en,
                 bus.fifo_count, i);
      end
    end
    bus.alu_data = 16'd5;
    #1;
    n_cmp++;
    if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_full got alu=%b mem=%b want 0/0", bus.alu_ready, bus.mem_ready);
    end
    tick();
    n_cmp++;
    if (bus.fifo_count !== 3'd4 || bus.wb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_stall got cnt=%0d en=%b want 4/0", bus.fifo_count, bus.wb_en);
    end
    bus.wb_hold = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 2) bus.alu_valid = 1'b0;
      n_cmp++;
      if (bus.wb_en !== 1'b1 || bus.wb_data !== 16'(i)) begin
        n_fail++;
        $display("FAIL hold_drain%0d got en=%b data=%h want 1/%h", i, bus.wb_en,
                 bus.wb_data, 16'(i));
      end
    end
    tick();
    n_cmp++;
    if (bus.wb_en !== 1'b0 || bus.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL hold_end got en=%b cnt=%0d want 0/0", bus.wb_en, bus.fifo_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    for (int j = 0; j < 8; j++) begin
      bus.mem_valid = (j % 2 == 0);
      bus.alu_valid = (j % 2 == 1);
      bus.mem_dest  = 3'(j);
      bus.alu_dest  = 3'(j);
      bus.mem_data  = 16'h0100 + 16'(j);
      bus.alu_data  = 16'h0200 + 16'(j);
      tick();
      n_cmp++;
      if (bus.fifo_count !== 3'd1) begin
        n_fail++;
        $display("FAIL b2b_cnt%0d got %0d want 1", j, bus.fifo_count);
      end
      if (j > 0) begin
        want = ((j - 1) % 2 == 0) ? 16'h0100 + 16'(j - 1) : 16'h0200 + 16'(j - 1);
        n_cmp++;
        if (bus.wb_en !== 1'b1 || bus.wb_data !== want) begin
          n_fail++;
          $display("FAIL b2b_wb%0d got en=%b data=%h want 1/%h", j, bus.wb_en,
                   bus.wb_data, want);
        end
      end
    end
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus.wb_en !== 1'b1 || bus.wb_data !== 16'h0207 || bus.fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_last got en=%b data=%h cnt=%0d want 1/0207/0",
               bus.wb_en, bus.wb_data, bus.fifo_count);
    end
    tick();
    n_cmp++;
    if (bus.wb_en !== 1'b0 || rf[7] !== 16'h0207 || rf[6] !== 16'h0106) begin
      n_fail++;
      $display("FAIL b2b_idle got en=%b r7=%h r6=%h want 0/0207/0106",
               bus.wb_en, rf[7], rf[6]);
    end
  endtask

`ifdef GPR_WB_BYPASS_EN
  task automatic test_bypass();
    bus.byp_addr_1 = 3'd5;
    bus.byp_addr_2 = 3'd6;
    bus.wb_hold    = 1'b1;
    bus.alu_valid  = 1'b1;
    bus.alu_dest   = 3'd5;
    bus.alu_data   = 16'h0BEE;
    tick();
    bus.alu_data   = 16'h0CAF;
    tick();
    bus.alu_valid  = 1'b0;
    n_cmp++;
    if (bus.byp_hit_1 !== 1'b1 || bus.byp_data_1 !== 16'h0CAF) begin
      n_fail++;
      $display("FAIL byp_fifo got hit=%b data=%h want 1/0caf", bus.byp_hit_1, bus.byp_data_1);
    end
    n_cmp++;
    if (bus.byp_hit_2 !== 1'b0 || bus.byp_data_2 !== 16'h0000) begin
      n_fail++;
      $display("FAIL byp_miss got hit=%b data=%h want 0/0000", bus.byp_hit_2, bus.byp_data_2);
    end
    bus.wb_hold = 1'b0;
    tick();  // wb holds 0x0BEE, FIFO still holds 0x0CAF
    n_cmp++;
    if (bus.byp_hit_1 !== 1'b1 || bus.byp_data_1 !== 16'h0CAF) begin
      n_fail++;
      $display("FAIL byp_young got hit=%b data=%h want 1/0caf", bus.byp_hit_1, bus.byp_data_1);
    end
    tick();  // only the wb register matches
    n_cmp++;
    if (bus.byp_hit_1 !== 1'b1 || bus.byp_data_1 !== 16'h0CAF) begin
      n_fail++;
      $display("FAIL byp_wbreg got hit=%b data=%h want 1/0caf", bus.byp_hit_1, bus.byp_data_1);
    end
    tick();
    n_cmp++;
    if (bus.byp_hit_1 !== 1'b0 || bus.byp_data_1 !== 16'h0000) begin
      n_fail++;
      $display("FAIL byp_gone got hit=%b data=%h want 0/0000", bus.byp_hit_1, bus.byp_data_1);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    bus.alu_valid = 1'b0;
    bus.alu_dest  = '0;
    bus.alu_data  = '0;
    bus.mem_valid = 1'b0;
    bus.mem_dest  = '0;
    bus.mem_data  = '0;
    bus.wb_hold   = 1'b0;
`ifdef GPR_WB_BYPASS_EN
    bus.byp_addr_1 = '0;
    bus.byp_addr_2 = '0;
`endif
    test_reset();
    test_reset_flush();
    test_single_write();
    test_priority();
    test_hold();
    test_back_to_back();
`ifdef GPR_WB_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/gpr_writeback.md
Name: gpr_writeback

Overview:
Write-back sequencer that drives the write port of the 8x16-bit general-purpose register file.
- Accepts results from two producers, the ALU and the load/memory unit, using valid/ready handshakes.
- Buffers accepted results in a small in-order FIFO.
- Issues exactly one register write per cycle on wb_en/wb_dest/wb_data.
- Sits between the execute/memory stages and the register file; its outputs connect directly to the register file's write_en/write_dest/write_data.

Parameters:
DATA_W, 16, width of result data and register contents
ADDR_W, 3, register index width (8 registers)
FIFO_DEPTH, 4, number of buffered write-back entries; power of two, >= 2

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
alu_dest  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
mem_valid  in  1  load result present
mem_ready  out  1  load result accepted this cycle when mem_valid=1
mem_dest  in  ADDR_W  load destination register
mem_data  in  DATA_W  load result
wb_hold  in  1  stall write-back (register port borrowed); no pop while 1
wb_en  out  1  register-file write enable
wb_dest  out  ADDR_W  register-file write destination
wb_data  out  DATA_W  register-file write data
fifo_count  out  $clog2(FIFO_DEPTH+1)  current number of buffered entries

Behaviour:
- Reset (rst=1, asynchronous, takes effect without a clock edge):
  - wb_en=0, wb_dest=0, wb_data=0, fifo_count=0.
  - Read/write pointers are cleared to 0.
  - Buffered entries are discarded; no write is issued for them.
  - alu_ready=mem_ready=1 on the first cycle after rst deasserts.
- Accept (at most one push per cycle):
  - full = (fifo_count == FIFO_DEPTH).
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid. Fixed priority: the load unit wins.
  - On a handshake (valid && ready) at edge k, {dest, data} is pushed to the tail.
  - A producer holds its valid/dest/data stable until ready; losing arbitration is not a drop.
  - ready depends only on fifo_count and mem_valid; a pop in the same cycle does not free a slot for that cycle (no pass-through).
- Issue:
  - wb_en, wb_dest and wb_data are registered.
  - At each edge with fifo_count>0 and wb_hold=0, the head entry is popped and loaded into wb_dest/wb_data, and wb_en is set to 1.
  - At each edge with no pop, wb_en=0; wb_dest/wb_data hold their last values.
  - Each entry produces exactly one single-cycle wb_en pulse.
- Latency and throughput:
  - Accept at edge k, pop at edge k+1, wb_en=1 during cycle k+1..k+2, register file captures at edge k+2.
  - Sustained throughput is one write per cycle.
- Counting:
  - fifo_count += push, -= pop.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering:
  - Writes issue strictly in acceptance order.
  - Multiple pending writes to the same register all issue in order, so the last accepted value persists.
- Hold:
  - wb_hold=1 forces wb_en=0 from the next edge onward.
  - The FIFO fills up to FIFO_DEPTH, then both readies drop to 0.
  - Releasing wb_hold resumes pops at the next edge.
- Invariants: no push when full; no pop when empty (empty with wb_hold=0 gives wb_en=0); fifo_count never exceeds FIFO_DEPTH.

Optional Feature:
GPR_WB_BYPASS_EN
- Defined: adds inputs byp_addr_1/byp_addr_2 (ADDR_W) and outputs byp_hit_1/byp_hit_2 (1) and byp_data_1/byp_data_2 (DATA_W).
  - Each lookup searches the wb output register (when wb_en=1) and all valid FIFO entries; the search is combinational.
  - The youngest matching entry wins; a valid FIFO entry counts as younger than the wb register.
  - Hit gives byp_hit=1 and the matching data; miss gives byp_hit=0 and byp_data=0.
  - Used by decode to forward pending results.
- Undefined: the bypass ports and search logic are absent; the core behaviour is identical.

Test Plan:
1. Push 3 entries with wb_hold=1, then pulse rst between edges -> wb_en=0, fifo_count=0 immediately; after release, readies=1 and no stale writes ever appear.
2. alu_valid with dest=3, data=0x00A5 accepted at edge k -> wb_en=1, wb_dest=3, wb_data=0x00A5 only during cycle k+1..k+2; register r3 reads 0x00A5 after edge k+2.
3. mem (dest 2, 0x1111) and alu (dest 2, 0x2222) valid in the same cycle -> mem_ready=1, alu_ready=0; alu accepted next cycle; writes issue 0x1111 then 0x2222; r2 ends at 0x2222.
4. wb_hold=1 with 5 alu pushes of data 1..5 -> fifo_count reaches 4, alu_ready=0 with the 5th stalled; release hold -> 5 consecutive wb_en pulses with data 1,2,3,4,5.
5. Back-to-back alternating mem/alu pushes over 8 cycles with wb_hold=0 -> fifo_count stays <=1, one wb_en per cycle, order preserved.
6. (GPR_WB_BYPASS_EN) Pending r5=0x0BEE then r5=0x0CAF, byp_addr_1=5 -> byp_hit_1=1, byp_data_1=0x0CAF; byp_addr_2=6 -> byp_hit_2=0, byp_data_2=0.
